// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular instruction FIFO between fetch and decode.
// Words are buffered with their PC and handed to the decoder one per cycle
// over a valid/ready handshake. A flush empties the queue in one cycle.
// Optional feature macro: FQ_BYPASS_EN. When it is defined, an empty queue
// forwards the incoming fetch word straight to the decoder in the same
// cycle, and only stores it if the decoder is not ready to take it.

module inst_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter int          PTR_W    = 3,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_inst,
    input  logic [31:0]      push_pc,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [31:0]      pop_inst,
    output logic [31:0]      pop_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Each entry holds {inst, pc}; storage is deliberately not reset.
    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;

    logic             not_empty;
    logic             bypass;
    logic             bypass_take;
    logic             store_push;
    logic             store_pop;
    logic [63:0]      head_entry;

    assign not_empty  = (cnt != '0);
    assign push_ready = (cnt != CNT_FULL);
    assign count      = cnt;
    assign head_entry = mem[rd_ptr];

`ifdef FQ_BYPASS_EN
    assign bypass      = (cnt == '0) && push_valid && !flush;
    assign bypass_take = bypass && pop_ready;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // Handshake fires: a word consumed through the bypass never touches storage.
    always_comb begin
        store_push = push_valid && push_ready && !flush && !bypass_take;
        store_pop  = not_empty && pop_ready && !flush;
    end

    // Decoder-facing outputs: head entry, bypassed fetch word, or a NOP when idle.
    always_comb begin
        pop_valid = not_empty;
        pop_inst  = NOP_INST;
        pop_pc    = '0;
        if (not_empty) begin
            pop_inst = head_entry[63:32];
            pop_pc   = head_entry[31:0];
        end else if (bypass) begin
            pop_valid = 1'b1;
            pop_inst  = push_inst;
            pop_pc    = push_pc;
        end
    end

    // Write the incoming word at the tail when a push is stored.
    always_ff @(posedge clk) begin
        if (!reset && store_push) begin
            mem[wr_ptr] <= {push_inst, push_pc};
        end
    end

    // Pointer and occupancy update; reset wins over flush, flush over traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (store_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({store_push, store_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized and directed bench for inst_fetch_queue,
// checked cycle by cycle against a queue-based reference model.
// Honors FQ_BYPASS_EN the same way as the design.

module tb_inst_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam int          PTR_W    = 3;
    localparam logic [31:0] NOP_INST = 32'h00000013;

`ifdef FQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             flush;
    logic             push_valid;
    logic             push_ready;
    logic [31:0]      push_inst;
    logic [31:0]      push_pc;
    logic             pop_valid;
    logic             pop_ready;
    logic [31:0]      pop_inst;
    logic [31:0]      pop_pc;
    logic [PTR_W:0]   count;

    int               errorCount;
    int               checkCount;
    bit               checksOn;
    logic [63:0]      modelQ[$];

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_inst  (push_inst),
        .push_pc    (push_pc),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_inst   (pop_inst),
        .pop_pc     (pop_pc),
        .count      (count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, compare the combinational
    // outputs with the model, then advance the model to the state after the next
    // rising edge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit pv,
                                 input logic [31:0] inst, input logic [31:0] pc,
                                 input bit pr);
        int          size;
        bit          expValid;
        logic [31:0] expInst;
        logic [31:0] expPc;
        bit          bypassNow;
        @(negedge clk);
        reset      = rst;
        flush      = fl;
        push_valid = pv;
        push_inst  = inst;
        push_pc    = pc;
        pop_ready  = pr;
        #1;
        size      = modelQ.size();
        bypassNow = BYPASS && size == 0 && pv && !fl;
        expValid  = (size > 0) || bypassNow;
        expInst   = NOP_INST;
        expPc     = 32'h0;
        if (size > 0) begin
            expInst = modelQ[0][63:32];
            expPc   = modelQ[0][31:0];
        end else if (bypassNow) begin
            expInst = inst;
            expPc   = pc;
        end
        if (checksOn) begin
            checkOutput("pop_valid",  64'(pop_valid),  64'(expValid));
            checkOutput("pop_inst",   64'(pop_inst),   64'(expInst));
            checkOutput("pop_pc",     64'(pop_pc),     64'(expPc));
            checkOutput("push_ready", 64'(push_ready), 64'(size < DEPTH));
            checkOutput("count",      64'(count),      64'(size));
        end
        if (rst || fl) begin
            modelQ.delete();
        end else if (!(bypassNow && pr)) begin
            if (size > 0 && pr) begin
                void'(modelQ.pop_front());
            end
            if (pv && size < DEPTH) begin
                modelQ.push_back({inst, pc});
            end
        end
    endtask

    // Shorthand for a cycle with only handshake traffic.
    task automatic idleCycle(input bit pr);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pr);
    endtask

    initial begin
        bit          pv;
        bit          pr;
        bit          fl;
        bit          rst;
        logic [31:0] pcNext;

        errorCount = 0;
        checkCount = 0;
        checksOn   = 1'b0;
        reset      = 1'b1;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_inst  = 32'h0;
        push_pc    = 32'h0;
        pop_ready  = 1'b0;

        // Reset, then confirm idle outputs.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checksOn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idleCycle(1'b0);
        checkOutput("reset_nop", 64'(pop_inst), 64'(32'h00000013));
        checkOutput("reset_cnt", 64'(count), 64'd0);

        // Fill all eight entries with the decoder stalled.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h00100093 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h1020, 1'b0);
        checkOutput("full_cnt",   64'(count), 64'd8);
        checkOutput("full_ready", 64'(push_ready), 64'd0);
        idleCycle(1'b0);
        checkOutput("full_hold", 64'(count), 64'd8);

        // Drain in order, then the queue reads as empty with a NOP on pop_inst.
        for (int i = 0; i < DEPTH; i++) begin
            idleCycle(1'b1);
            checkOutput("drain_pc", 64'(pop_pc), 64'(32'h1000 + 32'(4 * i)));
        end
        idleCycle(1'b0);
        checkOutput("drain_nop", 64'(pop_inst), 64'(NOP_INST));

        // Continuous streaming wraps the pointers with occupancy held at one.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00200093, 32'h3000, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h00200093 + 32'(i), 32'h3000 + 32'(4 * i), 1'b1);
            checkOutput("stream_cnt", 64'(count), 64'd1);
        end
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Flush with five entries queued while push and pop both request.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h00300093 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h00300099, 32'h4100, 1'b1);
        idleCycle(1'b0);
        checkOutput("flush_cnt",   64'(count), 64'd0);
        checkOutput("flush_valid", 64'(pop_valid), 64'd0);

        // Empty-queue push with the decoder ready: same-cycle only with bypass.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400093, 32'h2000, 1'b1);
        checkOutput("byp_valid", 64'(pop_valid), 64'(BYPASS));
        idleCycle(1'b0);
        checkOutput("byp_cnt", 64'(count), BYPASS ? 64'd0 : 64'd1);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Randomized traffic with occasional flush and mid-stream reset.
        pcNext = 32'h8000;
        for (int i = 0; i < 600; i++) begin
            pv  = ($urandom_range(0, 99) < 60);
            pr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            fl  = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 199) < 1);
            applyStimulus(rst, fl, pv, $urandom, pcNext, pr);
            pcNext = pcNext + 32'd4;
        end
        idleCycle(1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Circular FIFO between the instruction-fetch stage and the decoder.
- Buffers fetched instruction words with their PCs and presents them one per cycle on a valid/ready interface.
- Decouples fetch from decode/dispatch stalls.
- Supports a single-cycle flush on branch mispredict or redirect, discarding all buffered words.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).
- NOP_INST, 32'h00000013, value driven on pop_inst when pop_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries this cycle.
- push_valid  input  1  fetch presents a word.
- push_ready  output  1  queue can accept a word.
- push_inst  input  32  instruction word.
- push_pc  input  32  PC of the instruction word.
- pop_valid  output  1  head entry is valid.
- pop_ready  input  1  decoder consumes the head.
- pop_inst  output  32  head instruction; drives the decoder's inst input.
- pop_pc  output  32  head PC.
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it takes effect only on a clk rising edge.
- State: wr_ptr and rd_ptr (PTR_W bits each, wrap modulo DEPTH), cnt (PTR_W+1 bits), storage array of DEPTH x 64 bits. Storage is not reset.
- Reset values: wr_ptr=0, rd_ptr=0, cnt=0. Resulting outputs: pop_valid=0, push_ready=1, count=0, pop_inst=NOP_INST, pop_pc=0.
- Combinational outputs:
  - push_ready = (cnt != DEPTH). No look-through: a full queue refuses a push even when a pop occurs in the same cycle.
  - pop_valid = (cnt != 0).
  - When pop_valid=1, pop_inst/pop_pc = storage[rd_ptr]; otherwise NOP_INST/0.
  - count = cnt.
- Push fire = push_valid & push_ready & !flush. On fire: write storage[wr_ptr], then wr_ptr+1.
- Pop fire = pop_valid & pop_ready & !flush. On fire: rd_ptr+1.
- cnt update: push only, +1; pop only, -1; both or neither, unchanged.
- Simultaneous push and pop with cnt=1: head is popped and the new word becomes head next cycle; cnt stays 1.
- Latency: a word pushed in cycle N appears on pop_* in cycle N+1 at the earliest.
- Flush: when flush=1 in a cycle, wr_ptr, rd_ptr and cnt all return to 0 at the next edge. Same-cycle push and pop are both ignored, and fetch must re-present a refused push.
- Priority: reset > flush > push/pop.
- Reset asserted mid-stream: identical to flush, and additionally forces the reset values listed above.
- Boundary and handshake rules:
  - Pointers wrap from DEPTH-1 to 0.
  - No overflow or underflow is possible, because fires are gated by push_ready and pop_valid.
  - pop_inst and pop_pc must remain stable while pop_valid=1 and pop_ready=0.
  - push_valid with push_ready=0 leaves state unchanged.

Optional Feature:
- Macro: FQ_BYPASS_EN.
- Defined: when cnt=0, push_valid=1 and flush=0, the queue bypasses storage:
  - pop_valid=1 combinationally, with pop_inst=push_inst and pop_pc=push_pc.
  - If pop_ready=1 in that cycle, the word is consumed and never written; pointers and cnt are unchanged (zero-cycle latency).
  - If pop_ready=0, a normal push occurs.
- Undefined: no combinational path from push_* to pop_*; minimum latency is 1 cycle.

Test Plan:
- Reset then idle: after reset, expect pop_valid=0, push_ready=1, count=0, pop_inst=32'h00000013.
- Fill: push 8 words (inst=32'h00100093+i, pc=32'h1000+4i) with pop_ready=0. Expect count=8 and push_ready=0; a 9th push is refused and count stays 8.
- Drain order: with pop_ready=1, the 8 pops return pc 32'h1000..32'h101C in order. count then reaches 0 and pop_inst returns to NOP.
- Wrap and simultaneous push/pop: stream 20 words with push_valid=1 and pop_ready=1 continuously. Expect count to hold at 1, all PCs in order, and pointers to wrap twice.
- Flush: with 5 entries queued, assert flush together with push_valid=1 and pop_ready=1. Next cycle expect count=0 and pop_valid=0; the pushed word is absent.
- FQ_BYPASS_EN: with the queue empty, push pc=32'h2000 with pop_ready=1. Expect pop_valid=1 and pop_pc=32'h2000 in the same cycle, and count=0 after the edge. Without the macro, pop_valid=1 appears one cycle later.
